net_input_loader: RTL and testbench

//   Upstream feeder for the 9-input, 3-layer Network. Accepts a serial stream of

---
 rtl/net_input_loader.sv | 149 ++++++++++++++
 tb/tb_net_input_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_input_loader.sv
// Serial sample loader for the 9-input network: frames samples into a
// shadow buffer and launches each full frame with a one-cycle start pulse.
module net_input_loader #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 100,
  parameter int FRAC_SHIFT = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [OUT_W-1:0] input_0,
  output logic [OUT_W-1:0] input_1,
  output logic [OUT_W-1:0] input_2,
  output logic [OUT_W-1:0] input_3,
  output logic [OUT_W-1:0] input_4,
  output logic [OUT_W-1:0] input_5,
  output logic [OUT_W-1:0] input_6,
  output logic [OUT_W-1:0] input_7,
  output logic [OUT_W-1:0] input_8,
  output logic             start,
  input  logic             net_done,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  if (IN_W + FRAC_SHIFT > OUT_W) begin : g_bad_width
    $error("IN_W + FRAC_SHIFT exceeds OUT_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] shadow_q [9];
  logic [OUT_W-1:0] shadow_d [9];
  logic [OUT_W-1:0] out_q [9];
  logic [OUT_W-1:0] out_d [9];
  logic [3:0]       idx_q, idx_d;
  logic             full_q, full_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [OUT_W-1:0] ext;
  logic        [OUT_W-1:0] conv;
  logic                    accept;
  logic                    load;

  assign ext    = OUT_W'($signed(s_data));
  assign conv   = ext <<< FRAC_SHIFT;
  assign s_ready = ~full_q & ~rst;
  assign accept = s_valid & s_ready;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    idx_d    = idx_q;
    full_d   = full_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    load     = 1'b0;

    // a misaligned s_last drops the whole partial frame
    if (accept) begin
      if (s_last == (idx_q == 4'd8)) begin
        shadow_d[idx_q] = conv;
        if (s_last) begin
          full_d = 1'b1;
          idx_d  = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        idx_d = 4'd0;
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (full_q) load = 1'b1;
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (net_done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (full_q) load = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // full_q is only cleared here, never set in the same cycle
    if (load) begin
      out_d   = shadow_q;
      full_d  = 1'b0;
      state_d = START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      full_q   <= full_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  assign start     = (state_q == START);
  assign busy      = (state_q != IDLE);
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

  assign input_0 = out_q[0];
  assign input_1 = out_q[1];
  assign input_2 = out_q[2];
  assign input_3 = out_q[3];
  assign input_4 = out_q[4];
  assign input_5 = out_q[5];
  assign input_6 = out_q[6];
  assign input_7 = out_q[7];
  assign input_8 = out_q[8];

endmodule

// File: tb/tb_net_input_loader.sv
// Scoreboard bench for net_input_loader: directed framing/launch cases
// followed by randomized streams with an auto-responding network.
module tb_net_input_loader;

  localparam int IN_W  = 32;
  localparam int OUT_W = 100;
  localparam int FRAC  = 8;
  localparam int CNT_W = 16;

  typedef logic [9*OUT_W-1:0] frame_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [IN_W-1:0]  s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             net_done = 1'b0;
  logic             s_ready;
  logic             start;
  logic             busy;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [OUT_W-1:0] o [9];

  always #5 clk = ~clk;

  net_input_loader #(
    .IN_W(IN_W),
    .OUT_W(OUT_W),
    .FRAC_SHIFT(FRAC),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .input_0(o[0]),
    .input_1(o[1]),
    .input_2(o[2]),
    .input_3(o[3]),
    .input_4(o[4]),
    .input_5(o[5]),
    .input_6(o[6]),
    .input_7(o[7]),
    .input_8(o[8]),
    .start(start),
    .net_done(net_done),
    .busy(busy),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [OUT_W-1:0] part [$];
  frame_t           exp_q [$];
  bit               exp_err = 1'b0;
  int               exp_cnt = 0;
  bit               auto_done = 1'b0;
  frame_t           cur;
  bit               have_cur = 1'b0;

  // reference conversion: signed value times 2^FRAC
  function automatic logic [OUT_W-1:0] conv(logic [IN_W-1:0] d);
    logic signed [OUT_W-1:0] v;
    v = {{(OUT_W-IN_W){d[IN_W-1]}}, d};
    return OUT_W'(v * (2 ** FRAC));
  endfunction

  task automatic chk(string nm, logic [OUT_W-1:0] act,
                     logic [OUT_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // frame-level model: a frame counts only if s_last lands on sample 9
  function automatic void model_accept(logic [IN_W-1:0] d, bit last);
    frame_t f;
    part.push_back(conv(d));
    if (last || part.size() == 9) begin
      if (last && part.size() == 9) begin
        for (int i = 0; i < 9; i++) f[i*OUT_W +: OUT_W] = part[i];
        exp_q.push_back(f);
      end else begin
        exp_err = 1'b1;
      end
      part.delete();
    end
  endfunction

  task automatic send(input logic [IN_W-1:0] d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (s_ready) model_accept(d, last);
    else chk("send timeout s_ready", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_done();
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
  endtask

  task automatic wait_start(string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start && n < 60);
    chk({nm, " start seen"}, start, 1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    net_done = 1'b0;
    part.delete();
    exp_q.delete();
    exp_err  = 1'b0;
    exp_cnt  = 0;
    have_cur = 1'b0;
    #1;
    chk("rst s_ready low", s_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst s_ready after", s_ready, 1);
    chk("rst start", start, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("rst input_%0d", i), o[i], 0);
    @(negedge clk);
  endtask

  // monitor: launched frames against scoreboard, held frames while busy
  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected start", start, 0);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          for (int i = 0; i < 9; i++)
            chk($sformatf("frame input_%0d", i), o[i],
                cur[i*OUT_W +: OUT_W]);
          chk("busy with start", busy, 1);
        end
      end else if (busy && have_cur) begin
        for (int i = 0; i < 9; i++)
          chk($sformatf("hold input_%0d", i), o[i],
              cur[i*OUT_W +: OUT_W]);
      end
    end
  end

  // network stand-in for the random phase
  initial begin
    @(negedge clk);
    forever begin
      if (auto_done && start && !rst) begin
        repeat (1 + $urandom_range(0, 5)) @(negedge clk);
        net_done = 1'b1;
        exp_cnt++;
        @(negedge clk);
        net_done = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin
    logic signed [OUT_W-1:0] e0;
    logic signed [OUT_W-1:0] e1;
    int n;

    @(negedge clk);
    do_reset();

    // T1: 1..9, latency and single pulse
    for (int k = 1; k <= 9; k++) send(IN_W'(k), k == 9);
    chk("t1 no early start", start, 0);
    @(negedge clk);
    chk("t1 start", start, 1);
    chk("t1 busy", busy, 1);
    chk("t1 s_ready back", s_ready, 1);
    @(negedge clk);
    chk("t1 one pulse", start, 0);
    chk("t1 busy held", busy, 1);
    pulse_done();
    exp_cnt++;
    chk("t1 busy clear", busy, 0);
    chk("t1 frame_cnt", frame_cnt, CNT_W'(exp_cnt));

    // T2: sign extension with scaling
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h8000_0000, 1'b0);
    for (int k = 2; k < 9; k++) send($urandom, k == 8);
    wait_start("t2");
    e0 = -256;
    e1 = {{61{1'b1}}, 39'b0};
    chk("t2 input_0", o[0], e0);
    chk("t2 input_1", o[1], e1);

    // T3: next frame waits in shadow while busy
    for (int k = 0; k < 9; k++) send($urandom, k == 8);
    #1;
    chk("t3 s_ready stall", s_ready, 0);
    repeat (3) @(negedge clk);
    chk("t3 no start yet", start, 0);
    pulse_done();
    exp_cnt++;
    chk("t3 back-to-back start", start, 1);
    chk("t3 frame_cnt", frame_cnt, CNT_W'(exp_cnt));
    @(negedge clk);
    pulse_done();
    exp_cnt++;
    chk("t3 frame_cnt 2", frame_cnt, CNT_W'(exp_cnt));
    chk("t3 idle", busy, 0);

    // T4: short frame flagged and discarded
    for (int k = 0; k < 5; k++) send($urandom, k == 4);
    chk("t4 frame_err", frame_err, exp_err);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 9; k++) send($urandom, k == 8);
    wait_start("t4");
    @(negedge clk);
    pulse_done();
    exp_cnt++;
    chk("t4 frame_err sticky", frame_err, 1);

    // T5: completion while idle is ignored
    repeat (2) @(negedge clk);
    pulse_done();
    @(negedge clk);
    chk("t5 frame_cnt", frame_cnt, CNT_W'(exp_cnt));
    chk("t5 busy", busy, 0);
    chk("t5 start", start, 0);

    // T6: reset mid-compute with partial shadow
    for (int k = 0; k < 9; k++) send($urandom, k == 8);
    wait_start("t6");
    @(negedge clk);
    for (int k = 0; k < 4; k++) send($urandom, 1'b0);
    do_reset();
    for (int k = 0; k < 9; k++) send($urandom, k == 8);
    wait_start("t6 clean");
    @(negedge clk);
    pulse_done();
    exp_cnt++;
    chk("t6 frame_cnt", frame_cnt, CNT_W'(exp_cnt));

    // random streams, occasional framing errors
    @(negedge clk);
    auto_done = 1'b1;
    for (int f = 0; f < 40; f++) begin
      bit bad;
      int len;
      bad = ($urandom_range(0, 9) == 0);
      len = bad ? int'($urandom_range(1, 9)) : 9;
      for (int i = 0; i < len; i++) begin
        bit last;
        last = bad ? (len < 9 && i == len - 1) : (i == 8);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send($urandom, last);
      end
    end
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    auto_done = 1'b0;
    chk("rand drained", exp_q.size() == 0 && !busy, 1);
    chk("rand frame_cnt", frame_cnt, CNT_W'(exp_cnt));
    chk("rand frame_err", frame_err, exp_err);
    chk("rand s_ready", s_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
